// File: rtl/inst_fetch_if.sv
// Byte-wide instruction memory port between the fetch stage and its memory.
interface inst_fetch_if;
  logic        mem_re_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i;

  modport master (output mem_re_o, output mem_addr_o, input mem_data_i);
  modport slave  (input mem_re_o, input mem_addr_o, output mem_data_i);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: four byte reads per 32-bit word, little-endian assembly,
// one-cycle flag_o pulse per delivered instruction, decode redirects and stall.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               branch_i,
  input  logic [31:0]        jump_addr_i,
  inst_fetch_if.master       mem,
  output logic [31:0]        pc_o,
  output logic [31:0]        inst_o,
  output logic               flag_o
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic        flag_q, flag_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S0;
      pc_q       <= RESET_PC;
      buf_q      <= '0;
      pc_out_q   <= '0;
      inst_out_q <= '0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      pc_out_q   <= pc_out_d;
      inst_out_q <= inst_out_d;
      flag_q     <= flag_d;
    end
  end

  // Each byte lands one cycle after its address, so capture lags issue by a state.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    buf_d          = buf_q;
    pc_out_d       = pc_out_q;
    inst_out_d     = inst_out_q;
    flag_d         = 1'b0;
    mem.mem_re_o   = 1'b0;
    mem.mem_addr_o = '0;
    case (state_q)
      S0: begin
        mem.mem_re_o   = 1'b1;
        mem.mem_addr_o = pc_q;
        state_d        = S1;
      end
      S1: begin
        mem.mem_re_o   = 1'b1;
        mem.mem_addr_o = pc_q + 32'd1;
        buf_d[7:0]     = mem.mem_data_i;
        state_d        = S2;
      end
      S2: begin
        mem.mem_re_o   = 1'b1;
        mem.mem_addr_o = pc_q + 32'd2;
        buf_d[15:8]    = mem.mem_data_i;
        state_d        = S3;
      end
      S3: begin
        mem.mem_re_o   = 1'b1;
        mem.mem_addr_o = pc_q + 32'd3;
        buf_d[23:16]   = mem.mem_data_i;
        state_d        = S4;
      end
      S4: begin
        buf_d[31:24]   = mem.mem_data_i;
        state_d        = DONE;
      end
      DONE: begin
        if (!stall_i) begin
          pc_out_d   = pc_q;
          inst_out_d = buf_q;
          flag_d     = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = S0;
        end
      end
      default: state_d = S0;
    endcase

    // Redirect overrides everything, including a completion in the same cycle.
    if (branch_i) begin
      pc_d       = jump_addr_i;
      state_d    = S0;
      flag_d     = 1'b0;
      pc_out_d   = pc_out_q;
      inst_out_d = inst_out_q;
    end
  end

  assign pc_o   = pc_out_q;
  assign inst_o = inst_out_q;
  assign flag_o = flag_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random redirects/stalls,
// checked against a per-instruction reference model.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] jaddr = '0;
  logic [31:0] pc_o, inst_o, pc2, inst2;
  logic        flag, flag2;
  logic [7:0]  mem_d, mem_d2;

  always #5 clk = ~clk;

  inst_fetch_if mif();
  inst_fetch_if mif2();

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_i(branch), .jump_addr_i(jaddr),
    .mem(mif.master), .pc_o(pc_o), .inst_o(inst_o), .flag_o(flag)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .stall_i(1'b0), .branch_i(1'b0), .jump_addr_i(32'h0),
    .mem(mif2.master), .pc_o(pc2), .inst_o(inst2), .flag_o(flag2)
  );

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    case (a)
      32'd0: mem_rd = 8'h13;
      32'd1: mem_rd = 8'h05;
      32'd2: mem_rd = 8'h10;
      32'd3: mem_rd = 8'h00;
      32'd4: mem_rd = 8'h93;
      32'd5: mem_rd = 8'h05;
      32'd6: mem_rd = 8'h20;
      32'd7: mem_rd = 8'h00;
      default: mem_rd = a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    word_at = {mem_rd(a + 32'd3), mem_rd(a + 32'd2), mem_rd(a + 32'd1), mem_rd(a)};
  endfunction

  always @(posedge clk) begin
    if (mif.mem_re_o)  mem_d  <= mem_rd(mif.mem_addr_o);
    if (mif2.mem_re_o) mem_d2 <= mem_rd(mif2.mem_addr_o);
  end
  assign mif.mem_data_i  = mem_d;
  assign mif2.mem_data_i = mem_d2;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: an instruction takes 4 byte cycles, 1 assembly cycle, then
  // waits in a delivery slot until stall drops; redirects restart immediately.
  logic [31:0] m_pc, m_pco, m_insto;
  int          m_cnt;
  logic        m_flag;
  int          cyc, last_flag;

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = rpc; m_cnt = 0; m_flag = 1'b0; m_pco = '0; m_insto = '0;
  endtask

  task automatic step(input logic br, input logic [31:0] ja, input logic st);
    chk("mem_re", mif.mem_re_o, m_cnt < 4);
    chk("mem_addr", mif.mem_addr_o, (m_cnt < 4) ? m_pc + 32'(m_cnt) : 32'h0);
    chk("flag", flag, m_flag);
    chk("pc_o", pc_o, m_pco);
    chk("inst_o", inst_o, m_insto);
    if (flag) last_flag = cyc;
    branch = br; jaddr = ja; stall = st;
    @(posedge clk);
    if (rst) begin
      m_flag = 1'b0;
      if (br) begin
        m_pc = ja; m_cnt = 0;
      end else if (m_cnt < 5) begin
        m_cnt++;
      end else if (!st) begin
        m_flag = 1'b1; m_pco = m_pc; m_insto = word_at(m_pc);
        m_pc = m_pc + 32'd4; m_cnt = 0;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  logic [31:0] held;
  logic        rb, rs;
  logic [31:0] rj;

  initial begin
    model_reset(32'h0);
    cyc = 0; last_flag = 0;
    repeat (2) @(negedge clk);
    chk("rst_flag", flag, 0);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_inst_o", inst_o, 0);
    rst = 1'b1;

    // Reset release: first two instructions, plus the wrapping instance.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        chk("first_addr", mif.mem_addr_o, 32'(i));
        chk("wrap_addr", mif2.mem_addr_o, 32'hFFFF_FFFC + 32'(i));
      end
      step(1'b0, 32'h0, 1'b0);
    end
    chk("c6_flag", flag, 1);
    chk("c6_inst", inst_o, 32'h0010_0513);
    chk("c6_pc", pc_o, 32'h0);
    chk("wrap_flag", flag2, 1);
    chk("wrap_pc_o", pc2, 32'hFFFF_FFFC);
    chk("wrap_next_addr", mif2.mem_addr_o, 32'h0);
    repeat (6) step(1'b0, 32'h0, 1'b0);
    chk("c12_flag", flag, 1);
    chk("c12_pc", pc_o, 32'h4);
    chk("c12_inst", inst_o, 32'h0020_0593);

    // Redirect during S2 of the fetch at pc 8.
    repeat (2) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) chk("br_addr", mif.mem_addr_o, 32'h100 + 32'(i));
      step(1'b0, 32'h0, 1'b0);
    end
    chk("br_flag", flag, 1);
    chk("br_pc", pc_o, 32'h100);

    // Three stall cycles while sitting in DONE.
    repeat (5) step(1'b0, 32'h0, 1'b0);
    held = inst_o;
    for (int i = 0; i < 3; i++) begin
      chk("stall_inst", inst_o, held);
      chk("stall_re", mif.mem_re_o, 0);
      step(1'b0, 32'h0, 1'b1);
    end
    step(1'b0, 32'h0, 1'b0);
    chk("stall_flag", flag, 1);
    chk("stall_gap", cyc - last_flag, 9);

    // Asynchronous reset in S3.
    repeat (3) step(1'b0, 32'h0, 1'b0);
    chk("pre_rst_state_addr", mif.mem_addr_o, 32'h10B);
    rst = 1'b0;
    #1;
    chk("arst_flag", flag, 0);
    chk("arst_pc_o", pc_o, 0);
    chk("arst_inst_o", inst_o, 0);
    model_reset(32'h0);
    step(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    repeat (7) step(1'b0, 32'h0, 1'b0);

    // Random redirects, stalls and targets.
    for (int i = 0; i < 600; i++) begin
      rb = ($urandom_range(0, 14) == 0);
      rs = ($urandom_range(0, 2) == 0);
      rj = ($urandom_range(0, 3) == 0) ? 32'($urandom) : {22'($urandom_range(0, 1023)), 2'b00, 8'h00};
      step(rb, rj, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
